// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky error flags and flush.
// Define SYNC_FIFO_PARITY_EN to store a parity bit per entry and report rperr on reads.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  winj_perr,
    output logic                  rperr
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int unsigned MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_WIDTH = DATA_WIDTH;
`endif

    logic [MEM_WIDTH-1:0] mem [DEPTH];
    logic [MEM_WIDTH-1:0] wr_entry;
    logic [MEM_WIDTH-1:0] rd_entry;
    logic                 rd_perr;

    logic [CW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rperr_q, rperr_d;

    logic wr_en;
    logic rd_en;

    // Flush wins over both requests; dropped requests must not touch the sticky flags.
    assign wr_en = winc && !full_q && !clr;
    assign rd_en = rinc && !empty_q && !clr;

    assign rd_entry = mem[rptr_q[ADDR_WIDTH-1:0]];

`ifdef SYNC_FIFO_PARITY_EN
    // Even parity: XOR over the whole stored word is zero for a clean entry.
    assign wr_entry = {(^wdata) ^ winj_perr, wdata};
    assign rd_perr  = ^rd_entry;
`else
    logic unused_winj_perr;
    assign unused_winj_perr = winj_perr;
    assign wr_entry         = wdata;
    assign rd_perr          = 1'b0;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        rdata_d = rdata_q;
        rperr_d = rperr_q;

        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            rperr_d = 1'b0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + CW'(1);
            end
            if (rd_en) begin
                rptr_d  = rptr_q + CW'(1);
                rdata_d = rd_entry[DATA_WIDTH-1:0];
                rperr_d = rd_perr;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (winc && full_q) begin
                ovf_d = 1'b1;
            end
            if (rinc && empty_q) begin
                udf_d = 1'b1;
            end
        end

        // Flags decode the next count so they line up with the registered wcount.
        full_d   = (count_d == DEPTH_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_CNT);
        aempty_d = (count_d <= AEMPTY_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
            rperr_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
            rperr_q  <= rperr_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= wr_entry;
        end
    end

    assign rdata        = rdata_q;
    assign rperr        = rperr_q;
    assign wfull        = full_q;
    assign rempty       = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign wcount       = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    a_count_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        count_q == (wptr_q - rptr_q));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= DEPTH_CNT);
    a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(full_q && empty_q));

endmodule
